stream_rr_arbiter: RTL and testbench

- Shares one valid/ready data stream sink, such as a checker, between NREQ valid/ready stream sources, such as generators.
- Uses round-robin arbitration with grant locking for up to BURST beats per grant.
- Output passes through a single registered stage, which also carries the winning source index.
- Sits between the generator instances and the checker in the BFM top.

---
 rtl/stream_rr_arbiter.sv | 177 +++++++++++++++++
 tb/tb_stream_rr_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_rr_arbiter.sv
// stream_rr_arbiter
//   Shares one valid/ready sink between NREQ valid/ready sources. Round-robin
//   arbitration with grant locking: a winner keeps the grant for up to BURST
//   beats, or until it drops valid. One registered output stage carries the
//   beat and the index of the requester that sourced it.
//
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous reset, active low
//   up_valid   : [NREQ]     per-requester valid
//   up_data    : [NREQ*DW]  per-requester data, slice i = [i*DW +: DW]
//   up_ready   : [NREQ]     per-requester ready (at most one bit high)
//   down_valid : registered output valid
//   down_data  : [DW] registered output data
//   down_id    : [IDW] requester index of down_data
//   down_ready : sink ready
//   stat_clr   : (ARB_STATS_EN only) clear beat counters
//   stat_beats : (ARB_STATS_EN only) [NREQ*32] beats accepted per requester
//
// Optional feature macro: ARB_STATS_EN (per-requester beat counters).

module stream_rr_arbiter #(
    parameter int DW    = 32,
    parameter int NREQ  = 4,
    parameter int BURST = 4,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      up_valid,
    input  logic [NREQ*DW-1:0]   up_data,
    output logic [NREQ-1:0]      up_ready,
    output logic                 down_valid,
    output logic [DW-1:0]        down_data,
    output logic [IDW-1:0]       down_id,
    input  logic                 down_ready
`ifdef ARB_STATS_EN
    ,
    input  logic                 stat_clr,
    output logic [NREQ*32-1:0]   stat_beats
`endif
);

    localparam int CW = (BURST > 1) ? $clog2(BURST) : 1;

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t         state, state_nxt;
    logic [IDW-1:0] ptr, ptr_nxt;
    logic [IDW-1:0] owner, owner_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic [IDW-1:0] gnt;
    logic [IDW-1:0] xfer_id;
    logic [DW-1:0]  xfer_data;
    logic           found;
    logic           accept;
    logic           xfer;

    function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] base, input int k);
        int j;
        j = int'(base) + k;
        if (j >= NREQ) j = j - NREQ;
        return IDW'(j);
    endfunction

    // (NREQ-1)+1 wraps to 0, so the pointer never leaves 0..NREQ-1
    function automatic logic [IDW-1:0] inc_wrap(input logic [IDW-1:0] i);
        return (i == IDW'(NREQ - 1)) ? '0 : i + 1'b1;
    endfunction

    assign accept = !down_valid || down_ready;

    // First valid requester at or after ptr, wrapping
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && up_valid[rr_idx(ptr, k)]) begin
                found = 1'b1;
                gnt   = rr_idx(ptr, k);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        owner_nxt = owner;
        cnt_nxt   = cnt;
        up_ready  = '0;
        xfer      = 1'b0;
        xfer_id   = '0;
        if (rst) begin
            case (state)
                IDLE: begin
                    if (accept && found) begin
                        up_ready[gnt] = 1'b1;
                        xfer          = 1'b1;
                        xfer_id       = gnt;
                        if (BURST == 1) begin
                            ptr_nxt = inc_wrap(gnt);
                        end else begin
                            owner_nxt = gnt;
                            cnt_nxt   = CW'(1);
                            state_nxt = LOCKED;
                        end
                    end
                end
                LOCKED: begin
                    // Owner validity is checked ahead of accept so a source
                    // that goes quiet releases the grant even under backpressure.
                    if (!up_valid[owner]) begin
                        state_nxt = IDLE;
                        ptr_nxt   = inc_wrap(owner);
                        cnt_nxt   = '0;
                    end else if (accept) begin
                        up_ready[owner] = 1'b1;
                        xfer            = 1'b1;
                        xfer_id         = owner;
                        if (int'(cnt) + 1 == BURST) begin
                            state_nxt = IDLE;
                            ptr_nxt   = inc_wrap(owner);
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = cnt + 1'b1;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign xfer_data = up_data[int'(xfer_id)*DW +: DW];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            ptr        <= '0;
            owner      <= '0;
            cnt        <= '0;
            down_valid <= 1'b0;
            down_data  <= '0;
            down_id    <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            owner <= owner_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                down_valid <= xfer;
                if (xfer) begin
                    down_data <= xfer_data;
                    down_id   <= xfer_id;
                end
            end
        end
    end

`ifdef ARB_STATS_EN
    logic [31:0] stat_cnt [NREQ];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (!rst || stat_clr)
                stat_cnt[i] <= '0;
            else if (up_valid[i] && up_ready[i])
                stat_cnt[i] <= stat_cnt[i] + 32'd1;
        end
    end

    for (genvar i = 0; i < NREQ; i++) begin : g_stat
        assign stat_beats[i*32 +: 32] = stat_cnt[i];
    end
`endif

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Testbench for stream_rr_arbiter (NREQ=4, BURST=4, DW=32).
// Source queues feed the requesters; every upstream handshake pushes the
// expected {id,data} onto a scoreboard that is popped on each downstream beat.
// Define ARB_STATS_EN to also exercise the beat counters.

module tb_stream_rr_arbiter;

    localparam int DW    = 32;
    localparam int NREQ  = 4;
    localparam int BURST = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NREQ-1:0]   up_valid;
    logic [NREQ*DW-1:0] up_data;
    logic [NREQ-1:0]   up_ready;
    logic              down_valid;
    logic [DW-1:0]     down_data;
    logic [1:0]        down_id;
    logic              down_ready;
`ifdef ARB_STATS_EN
    logic              stat_clr;
    logic [NREQ*32-1:0] stat_beats;
`endif

    always #5 clk = ~clk;

    stream_rr_arbiter #(.DW(DW), .NREQ(NREQ), .BURST(BURST)) dut (
        .clk        (clk),
        .rst        (rst),
        .up_valid   (up_valid),
        .up_data    (up_data),
        .up_ready   (up_ready),
        .down_valid (down_valid),
        .down_data  (down_data),
        .down_id    (down_id),
        .down_ready (down_ready)
`ifdef ARB_STATS_EN
        ,
        .stat_clr   (stat_clr),
        .stat_beats (stat_beats)
`endif
    );

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] data;
    } beat_t;

    beat_t       sb[$];
    logic [31:0] src_q [NREQ][$];
    bit [NREQ-1:0] src_en;
    int          id_log[$];
    bit          dv_log[$];
    bit          hs_log[$];
    int n_cmp, n_err, cyc, out_cnt, viol;
    int first_up, first_dv, first_out, last_out;
    int stall_left;
    bit stall_en, stall_done;
    logic [31:0] stall_val, held_d;
    logic [1:0]  held_id;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic clr_state();
        sb.delete();
        for (int i = 0; i < NREQ; i++) src_q[i].delete();
        src_en = '0;
        id_log.delete(); dv_log.delete(); hs_log.delete();
        cyc = 0; out_cnt = 0;
        first_up = -1; first_dv = -1; first_out = -1; last_out = -1;
        stall_left = 0; stall_en = 0; stall_done = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; up_valid = '0; down_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        clr_state();
    endtask

    task automatic step();
        bit hs;
        beat_t e, b;
        @(negedge clk);
        if (stall_en && !stall_done && stall_left == 0 && down_valid && down_data == stall_val) begin
            stall_left = 5; stall_done = 1; held_d = down_data; held_id = down_id;
        end
        down_ready = (stall_left == 0);
        for (int i = 0; i < NREQ; i++) begin
            up_valid[i] = src_en[i] && (src_q[i].size() > 0);
            up_data[i*DW +: DW] = up_valid[i] ? src_q[i][0] : $urandom;
        end
        #1;
        if (stall_left > 0) begin
            chk("hold_valid", down_valid, 1);
            chk("hold_data", down_data, held_d);
            chk("hold_id", down_id, held_id);
            chk("hold_up_ready", up_ready, 0);
            stall_left--;
        end
        dv_log.push_back(down_valid);
        if (down_valid && first_dv < 0) first_dv = cyc;
        if (down_valid && down_ready) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("data", down_data, e.data);
                chk("id", down_id, e.id);
            end
            id_log.push_back(int'(down_id));
            out_cnt++;
            if (first_out < 0) first_out = cyc;
            last_out = cyc;
        end
        if (!$onehot0(up_ready)) viol++;
        hs = 0;
        for (int i = 0; i < NREQ; i++) begin
            if (up_valid[i] && up_ready[i]) begin
                b.id = 2'(i);
                b.data = src_q[i].pop_front();
                sb.push_back(b);
                hs = 1;
                if (first_up < 0) first_up = cyc;
            end
        end
        hs_log.push_back(hs);
        cyc++;
    endtask

    task automatic run_until(input int n, input int budget);
        int b;
        b = 0;
        while (out_cnt < n && b < budget) begin
            step();
            b++;
        end
        chk("beats_out", out_cnt, n);
        chk("sb_drained", sb.size(), 0);
    endtask

    task automatic fill_all(input int n);
        for (int i = 0; i < NREQ; i++)
            for (int k = 0; k < n; k++) src_q[i].push_back(32'((i << 8) | k));
        src_en = '1;
    endtask

    initial begin
        n_cmp = 0; n_err = 0; viol = 0;
        up_valid = '1; up_data = '0; down_ready = 1'b1;
`ifdef ARB_STATS_EN
        stat_clr = 1'b0;
`endif
        clr_state();

        // Reset state, with all requesters valid
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_down_valid", down_valid, 0);
        chk("rst_down_data", down_data, 0);
        chk("rst_down_id", down_id, 0);
        chk("rst_up_ready", up_ready, 0);

        // Single requester, 12 beats, latency and no bubbles across grants
        do_reset();
        for (int k = 0; k < 12; k++) src_q[0].push_back(32'h100 + k);
        src_en = 4'b0001;
        run_until(12, 40);
        chk("latency", first_dv - first_up, 1);
        chk("no_gaps", last_out - first_out, 11);

        // All requesters valid: bursts of 4 in round-robin order
        do_reset();
        fill_all(8);
        run_until(32, 60);
        for (int k = 0; k < 32 && k < id_log.size(); k++)
            chk("rr_order", id_log[k], (k / 4) % 4);

        // Backpressure for 5 cycles while 0x205 is on the output
        do_reset();
        for (int k = 0; k < 12; k++) src_q[2].push_back(32'h200 + k);
        src_en = 4'b0100;
        stall_en = 1; stall_val = 32'h205;
        run_until(12, 60);
        chk("stall_hit", stall_done, 1);
        chk("after_stall", (id_log.size() == 12) ? 1 : 0, 1);

        // Owner req1 drops valid after 2 beats
        do_reset();
        src_q[1].push_back(32'h110); src_q[1].push_back(32'h111);
        for (int k = 0; k < 4; k++) begin
            src_q[2].push_back(32'h220 + k);
            src_q[3].push_back(32'h330 + k);
        end
        src_en = 4'b1110;
        run_until(10, 40);
        begin
            int exp_ids [10] = '{1, 1, 2, 2, 2, 2, 3, 3, 3, 3};
            for (int k = 0; k < 10 && k < id_log.size(); k++) chk("release_ids", id_log[k], exp_ids[k]);
        end
        chk("release_hs0", hs_log[0], 1);
        chk("release_hs1", hs_log[1], 1);
        chk("release_idle", hs_log[2], 0);
        chk("release_hs3", hs_log[3], 1);
        chk("release_gap_dv", dv_log[3], 0);

        // Reset while LOCKED on req2 with a beat in flight
        do_reset();
        for (int k = 0; k < 8; k++) src_q[2].push_back(32'h240 + k);
        src_en = 4'b0100;
        step();
        step();
        @(negedge clk);
        chk("pre_rst_valid", down_valid, 1);
        rst = 1'b0; up_valid = '1; down_ready = 1'b1;
        #1;
        chk("rst_mid_up_ready", up_ready, 0);
        @(negedge clk);
        rst = 1'b1; up_valid = '0;
        #1;
        chk("rst_mid_down_valid", down_valid, 0);
        clr_state();
        fill_all(4);
        run_until(16, 40);
        for (int k = 0; k < 16 && k < id_log.size(); k++)
            chk("post_rst_order", id_log[k], (k / 4) % 4);

`ifdef ARB_STATS_EN
        // Counters after 20 beats: 0x4, 1x4, 2x4, 3x4, 0x4
        do_reset();
        for (int k = 0; k < 8; k++) src_q[0].push_back(32'h500 + k);
        for (int i = 1; i < NREQ; i++)
            for (int k = 0; k < 4; k++) src_q[i].push_back(32'h600 + (i << 4) + k);
        src_en = '1;
        run_until(20, 60);
        @(negedge clk);
        up_valid = '0;
        @(negedge clk);
        chk("stat0", stat_beats[0 +: 32], 8);
        chk("stat1", stat_beats[32 +: 32], 4);
        chk("stat2", stat_beats[64 +: 32], 4);
        chk("stat3", stat_beats[96 +: 32], 4);
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        chk("stat_clr", stat_beats, 0);
`endif

        chk("onehot_up_ready", viol, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
